decrypt_arbiter: RTL and testbench
==================================

Name: decrypt_arbiter

Overview:
Two-channel round-robin arbiter and sequencer for one shared multi-cycle 64-bit-block / 128-bit-key decryptor core (the synchronized decryptor). Each channel has its own key. The arbiter accepts one request at a time over a valid/ready handshake, starts the core, and waits for completion. It then returns the plaintext to the originating channel and holds it there until that channel accepts it. It sits between bus-side requesters and the decryptor core.

Parameters:
DATA_W, 64, block width
KEY_W, 128, key width
TIMEOUT_CYCLES, 255, max WAIT cycles before error (only with DEC_TIMEOUT_EN); range 1..65535

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ena  in  1  global enable; 0 freezes all state
r0_valid / r1_valid  in  1  request valid, channel 0/1
r0_ready / r1_ready  out  1  request accepted when valid&&ready
r0_block / r1_block  in  DATA_W  ciphertext
r0_key / r1_key  in  KEY_W  key
p0_valid / p1_valid  out  1  response valid
p0_ready / p1_ready  in  1  response accepted when valid&&ready
p0_block / p1_block  out  DATA_W  plaintext
p0_err / p1_err  out  1  response is a timeout error
core_start  out  1  one-cycle start pulse to core
core_block  out  DATA_W  latched ciphertext to core
core_key  out  KEY_W  latched key to core
core_done  in  1  core completion strobe
core_result  in  DATA_W  core plaintext, valid with core_done
busy  out  1  state != IDLE

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. State=IDLE. All outputs 0, including the latched block/key registers. last_grant=1, so channel 0 wins first. Reset mid-operation abandons the job. Any later core_done is ignored until the next job reaches WAIT.
- ena=0: state, registers and counter hold. r*_ready=0 and core_start=0. p*_valid/data/err hold their values, but no response handshake completes. core_done is not sampled.
- IDLE: rN_ready=1 only for granted channel N. Grant goes to the single valid channel. If both are valid, grant goes to the channel != last_grant. The grant decision is combinational from the current valids. On the transfer cycle: latch block, key and channel id, then go to ISSUE.
- ISSUE: core_start=1 for exactly one cycle. core_block/core_key drive the latched values and stay stable until the next accept. Next state is WAIT. core_done is ignored in ISSUE.
- WAIT: on core_done=1, capture core_result into pN_block, set pN_err=0, go to RESP.
- RESP: pN_valid=1 for the latched channel only; the other channel's p*_valid=0. On pN_ready=1: last_grant=N, clear pN_valid, go to IDLE. A new request cannot be accepted in that same cycle; the earliest accept is the next cycle.
- Latency: accept at cycle T, core_start at T+1. If core_done arrives at T+1+L (L>=1), pN_valid rises at T+2+L.
- Outstanding jobs: at most one. r*_ready stays 0 in ISSUE/WAIT/RESP.
- pN_block holds its last value after the handshake and updates only on the next capture for that channel.

Optional Feature:
DEC_TIMEOUT_EN:
- Defined: a counter clears on entry to WAIT and increments each enabled WAIT cycle. If core_done has not arrived when the counter reaches TIMEOUT_CYCLES, go to RESP with pN_block=0 and pN_err=1. core_done on the same cycle as the timeout takes priority (normal result, err=0).
- Undefined: no counter; WAIT lasts indefinitely; p*_err tied 0.

Test Plan:
1. Single job, stub core returns result=block^64'hFFFF_FFFF_FFFF_FFFF with L=3. Accept r0 with block 64'h0123456789ABCDEF -> core_start at T+1, p0_valid at T+5 with p0_block=64'hFEDCBA9876543210, p0_err=0, p1_valid=0.
2. Fairness. After reset, r0 and r1 both valid continuously for 4 jobs -> grant order 0,1,0,1. Each core_key matches the granted channel's key.
3. Backpressure. Hold p1_ready=0 for 5 cycles in RESP -> p1_valid/p1_block stable, r0_ready=0 throughout. Release -> IDLE next cycle, r0 accepted the cycle after.
4. ena=0 for 4 cycles in WAIT while the stub is also frozen -> no state change, core_start=0, response latency extended by exactly 4 cycles.
5. rst pulsed in WAIT, stub then asserts core_done -> all outputs 0, state stays IDLE. A following r1 job completes correctly.
6. DEC_TIMEOUT_EN with TIMEOUT_CYCLES=16 and a stub that never asserts done -> p0_valid after 16 WAIT cycles, p0_err=1, p0_block=0. A second run with done on the timeout cycle -> err=0 and real data.

Source files
------------

// File: rtl/decrypt_arbiter_if.sv
// Bus bundle for decrypt_arbiter: two request channels, two response
// channels and the shared decryptor core link.
// master: requesters plus core (drives requests, core_done/result).
// slave : the arbiter itself.
`timescale 1ns/1ps
interface decrypt_arbiter_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEY_W  = 128
);
  logic              r0_valid;
  logic              r0_ready;
  logic [DATA_W-1:0] r0_block;
  logic [KEY_W-1:0]  r0_key;
  logic              r1_valid;
  logic              r1_ready;
  logic [DATA_W-1:0] r1_block;
  logic [KEY_W-1:0]  r1_key;

  logic              p0_valid;
  logic              p0_ready;
  logic [DATA_W-1:0] p0_block;
  logic              p0_err;
  logic              p1_valid;
  logic              p1_ready;
  logic [DATA_W-1:0] p1_block;
  logic              p1_err;

  logic              core_start;
  logic [DATA_W-1:0] core_block;
  logic [KEY_W-1:0]  core_key;
  logic              core_done;
  logic [DATA_W-1:0] core_result;

  modport master (
    output r0_valid, r0_block, r0_key, input r0_ready,
    output r1_valid, r1_block, r1_key, input r1_ready,
    input  p0_valid, p0_block, p0_err, output p0_ready,
    input  p1_valid, p1_block, p1_err, output p1_ready,
    input  core_start, core_block, core_key,
    output core_done, core_result
  );

  modport slave (
    input  r0_valid, r0_block, r0_key, output r0_ready,
    input  r1_valid, r1_block, r1_key, output r1_ready,
    output p0_valid, p0_block, p0_err, input p0_ready,
    output p1_valid, p1_block, p1_err, input p1_ready,
    output core_start, core_block, core_key,
    input  core_done, core_result
  );
endinterface

// File: rtl/decrypt_arbiter.sv
// decrypt_arbiter: two-channel round-robin front end for one shared
// multi-cycle block decryptor. One job in flight at a time:
// IDLE (grant/accept) -> ISSUE (start pulse) -> WAIT (core busy) -> RESP.
// Optional macro DEC_TIMEOUT_EN: bounds WAIT to TIMEOUT_CYCLES enabled
// cycles and returns an error response (block 0, err 1) on expiry.
`timescale 1ns/1ps
module decrypt_arbiter #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned KEY_W          = 128,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  decrypt_arbiter_if.slave bus,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              last_grant;
  logic              chan;
  logic              grant;
  logic              req_any;
  logic              accept;
  logic              done_hit;
  logic              timeout_hit;
  logic              capture;
  logic              resp_fire;
  logic [DATA_W-1:0] cap_data;

  logic [DATA_W-1:0] block_q;
  logic [KEY_W-1:0]  key_q;
  logic              p0_valid_q;
  logic              p1_valid_q;
  logic [DATA_W-1:0] p0_block_q;
  logic [DATA_W-1:0] p1_block_q;

  // Grant and handshake qualifiers; everything is gated by ena so a frozen
  // cycle completes no transfer and samples no core_done.
  always_comb begin
    req_any = bus.r0_valid | bus.r1_valid;
    if (bus.r0_valid && bus.r1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = bus.r1_valid;
    end
    accept    = ena && (state == S_IDLE) && req_any;
    done_hit  = ena && (state == S_WAIT) && bus.core_done;
    resp_fire = ena && (state == S_RESP) &&
                (chan ? bus.p1_ready : bus.p0_ready);
  end

`ifdef DEC_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        p0_err_q;
  logic        p1_err_q;

  // The counter value is the number of enabled WAIT cycles already spent;
  // the cycle that would make it reach TIMEOUT_CYCLES is the expiry cycle.
  always_comb begin
    timeout_hit = ena && (state == S_WAIT) && !bus.core_done &&
                  (wait_cnt == TIMEOUT_LAST);
  end

  // WAIT cycle counter, cleared while issuing so it starts at 0 in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (ena) begin
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

  // Error flags follow the capture source: timeout sets, core_done clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_err_q <= 1'b0;
      p1_err_q <= 1'b0;
    end else if (capture) begin
      if (chan) begin
        p1_err_q <= timeout_hit;
      end else begin
        p0_err_q <= timeout_hit;
      end
    end
  end

  assign bus.p0_err = p0_err_q;
  assign bus.p1_err = p1_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.p0_err  = 1'b0;
  assign bus.p1_err  = 1'b0;
`endif

  // Capture data: real result wins over a coincident timeout.
  always_comb begin
    capture  = done_hit || timeout_hit;
    cap_data = done_hit ? bus.core_result : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: if (ena) state_nxt = S_WAIT;
      S_WAIT:  if (capture) state_nxt = S_RESP;
      S_RESP:  if (resp_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.r0_ready   = accept && !grant;
    bus.r1_ready   = accept && grant;
    bus.core_start = ena && (state == S_ISSUE);
    busy           = (state != S_IDLE);
  end

  // Job latch, response registers and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      chan       <= 1'b0;
      block_q    <= '0;
      key_q      <= '0;
      p0_valid_q <= 1'b0;
      p1_valid_q <= 1'b0;
      p0_block_q <= '0;
      p1_block_q <= '0;
    end else begin
      if (accept) begin
        chan    <= grant;
        block_q <= grant ? bus.r1_block : bus.r0_block;
        key_q   <= grant ? bus.r1_key : bus.r0_key;
      end
      if (capture) begin
        if (chan) begin
          p1_valid_q <= 1'b1;
          p1_block_q <= cap_data;
        end else begin
          p0_valid_q <= 1'b1;
          p0_block_q <= cap_data;
        end
      end
      if (resp_fire) begin
        if (chan) begin
          p1_valid_q <= 1'b0;
        end else begin
          p0_valid_q <= 1'b0;
        end
        last_grant <= chan;
      end
    end
  end

  assign bus.core_block = block_q;
  assign bus.core_key   = key_q;
  assign bus.p0_valid   = p0_valid_q;
  assign bus.p1_valid   = p1_valid_q;
  assign bus.p0_block   = p0_block_q;
  assign bus.p1_block   = p1_block_q;

endmodule

// File: tb/tb_decrypt_arbiter.sv
// Self-checking bench for decrypt_arbiter: stub core (result = ~block after
// L enabled cycles), a transaction-level reference model compared on every
// negedge, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_decrypt_arbiter;
  localparam int unsigned DW = 64;
  localparam int unsigned KW = 128;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic busy;

  decrypt_arbiter_if #(.DATA_W(DW), .KEY_W(KW)) bus ();

  decrypt_arbiter #(
    .DATA_W(DW), .KEY_W(KW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .bus(bus.slave), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_on = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stub core ----------------
  int       stub_l = 3;
  bit       stub_never = 1'b0;
  logic [7:0] stub_cnt = '0;

  always @(posedge clk) begin
    if (ena) begin
      if (bus.core_start) stub_cnt <= 8'(stub_l);
      else if (stub_cnt != 0) stub_cnt <= stub_cnt - 8'd1;
    end
  end
  assign bus.core_done   = !stub_never && (stub_cnt == 8'd1);
  assign bus.core_result = bus.core_block ^ {DW{1'b1}};

  // ---------------- reference model ----------------
  function automatic logic pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  logic          m_busy, m_start, m_wait, m_resp, m_chan, m_last;
  int            m_cnt;
  logic          m_pv [2];
  logic [DW-1:0] m_pb [2];
  logic          m_pe [2];
  logic [DW-1:0] m_cb;
  logic [KW-1:0] m_ck;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_start <= 0; m_wait <= 0; m_resp <= 0;
      m_chan <= 0; m_last <= 1; m_cnt <= 0;
      m_pv[0] <= 0; m_pv[1] <= 0; m_pb[0] <= '0; m_pb[1] <= '0;
      m_pe[0] <= 0; m_pe[1] <= 0; m_cb <= '0; m_ck <= '0;
    end else if (ena) begin
      if (!m_busy) begin
        if (bus.r0_valid || bus.r1_valid) begin
          m_chan  <= pick(bus.r0_valid, bus.r1_valid, m_last);
          m_cb    <= pick(bus.r0_valid, bus.r1_valid, m_last) ? bus.r1_block : bus.r0_block;
          m_ck    <= pick(bus.r0_valid, bus.r1_valid, m_last) ? bus.r1_key : bus.r0_key;
          m_busy  <= 1;
          m_start <= 1;
        end
      end else if (m_start) begin
        m_start <= 0; m_wait <= 1; m_cnt <= 0;
      end else if (m_wait) begin
        if (bus.core_done) begin
          m_wait <= 0; m_resp <= 1;
          m_pv[m_chan] <= 1; m_pb[m_chan] <= ~m_cb; m_pe[m_chan] <= 0;
        end
`ifdef DEC_TIMEOUT_EN
        else if (m_cnt + 1 == int'(TO)) begin
          m_wait <= 0; m_resp <= 1;
          m_pv[m_chan] <= 1; m_pb[m_chan] <= '0; m_pe[m_chan] <= 1;
        end
`endif
        else m_cnt <= m_cnt + 1;
      end else if (m_resp) begin
        if (m_chan ? bus.p1_ready : bus.p0_ready) begin
          m_pv[m_chan] <= 0; m_resp <= 0; m_busy <= 0; m_last <= m_chan;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_on) begin
      chk("r0_ready", bus.r0_ready, ena && !m_busy && (bus.r0_valid || bus.r1_valid) &&
          !pick(bus.r0_valid, bus.r1_valid, m_last));
      chk("r1_ready", bus.r1_ready, ena && !m_busy && (bus.r0_valid || bus.r1_valid) &&
          pick(bus.r0_valid, bus.r1_valid, m_last));
      chk("core_start", bus.core_start, ena && m_start);
      chk("core_block", bus.core_block, m_cb);
      chk("core_key", bus.core_key, m_ck);
      chk("busy", busy, m_busy);
      chk("p0_valid", bus.p0_valid, m_pv[0]);
      chk("p1_valid", bus.p1_valid, m_pv[1]);
      chk("p0_block", bus.p0_block, m_pb[0]);
      chk("p1_block", bus.p1_block, m_pb[1]);
      chk("p0_err", bus.p0_err, m_pe[0]);
      chk("p1_err", bus.p1_err, m_pe[1]);
    end
  end

  // ---------------- grant recorder ----------------
  bit            rec_on = 1'b0;
  int            grants [$];
  logic [KW-1:0] keys [$];

  always @(posedge clk) begin
    if (rec_on && !rst && ena) begin
      if (bus.r0_valid && bus.r0_ready) grants.push_back(0);
      if (bus.r1_valid && bus.r1_ready) grants.push_back(1);
      if (bus.core_start) keys.push_back(bus.core_key);
    end
  end

  // ---------------- tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input bit ch, input logic [DW-1:0] b, input logic [KW-1:0] k);
    int n = 0;
    if (ch) begin bus.r1_valid = 1'b1; bus.r1_block = b; bus.r1_key = k; end
    else    begin bus.r0_valid = 1'b1; bus.r0_block = b; bus.r0_key = k; end
    #1;
    while (!(ch ? bus.r1_ready : bus.r0_ready) && n < 50) begin tick(); n++; end
    chk("send_ready", ch ? bus.r1_ready : bus.r0_ready, 1'b1);
    tick();
    if (ch) bus.r1_valid = 1'b0; else bus.r0_valid = 1'b0;
  endtask

  task automatic wait_pvalid(input bit ch, output int n);
    n = 0;
    while (!(ch ? bus.p1_valid : bus.p0_valid) && n < 100) begin tick(); n++; end
    chk("pvalid_seen", ch ? bus.p1_valid : bus.p0_valid, 1'b1);
  endtask

  task automatic release_resp(input bit ch);
    if (ch) bus.p1_ready = 1'b1; else bus.p0_ready = 1'b1;
    tick();
    if (ch) bus.p1_ready = 1'b0; else bus.p0_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  localparam logic [KW-1:0] K0 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [KW-1:0] K1 = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;
  localparam logic [DW-1:0] B0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] B1 = 64'hCAFE_F00D_1234_5678;

  initial begin
    int n, m;
    int exp_g [4];
    logic [DW-1:0] held;
    exp_g = '{0, 1, 0, 1};
    bus.r0_valid = 0; bus.r1_valid = 0; bus.p0_ready = 0; bus.p1_ready = 0;
    bus.r0_block = '0; bus.r1_block = '0; bus.r0_key = '0; bus.r1_key = '0;

    repeat (2) tick();
    rst = 1'b0;
    check_on = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_p0_valid", bus.p0_valid, 1'b0);
    chk("rst_core_block", bus.core_block, '0);
    chk("rst_core_key", bus.core_key, '0);

    // 1: single job, L=3
    stub_l = 3;
    send(0, B0, K0);
    chk("t1_core_start", bus.core_start, 1'b1);
    wait_pvalid(0, n);
    chk("t1_latency", 128'(n), 128'd4);
    chk("t1_p0_block", bus.p0_block, 128'h0000_0000_0000_0000_FEDC_BA98_7654_3210);
    chk("t1_p0_err", bus.p0_err, 1'b0);
    chk("t1_p1_valid", bus.p1_valid, 1'b0);
    release_resp(0);

    // 2: fairness after reset
    pulse_reset();
    stub_l = 1;
    bus.p0_ready = 1; bus.p1_ready = 1;
    grants.delete(); keys.delete();
    rec_on = 1;
    bus.r0_block = B0; bus.r0_key = K0; bus.r1_block = B1; bus.r1_key = K1;
    bus.r0_valid = 1; bus.r1_valid = 1;
    n = 0;
    while (grants.size() < 4 && n < 200) begin tick(); n++; end
    bus.r0_valid = 0; bus.r1_valid = 0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    rec_on = 0;
    bus.p0_ready = 0; bus.p1_ready = 0;
    chk("t2_grant_count", 128'(grants.size()), 128'd4);
    chk("t2_key_count", 128'(keys.size()), 128'd4);
    if (grants.size() == 4 && keys.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_grant", 128'(grants[i]), 128'(exp_g[i]));
        chk("t2_key", keys[i], (exp_g[i] == 1) ? K1 : K0);
      end
    end

    // 3: backpressure on channel 1 while r0 waits
    stub_l = 2;
    send(1, B1, K1);
    bus.r0_valid = 1; bus.r0_block = B0; bus.r0_key = K0;
    wait_pvalid(1, n);
    held = bus.p1_block;
    chk("t3_p1_block", bus.p1_block, 128'h0000_0000_0000_0000_3501_0FF2_EDCB_A987);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_p1_valid_hold", bus.p1_valid, 1'b1);
      chk("t3_p1_block_hold", bus.p1_block, held);
      chk("t3_r0_ready_low", bus.r0_ready, 1'b0);
    end
    release_resp(1);
    chk("t3_idle_after", busy, 1'b0);
    chk("t3_r0_ready_next", bus.r0_ready, 1'b1);
    tick();
    bus.r0_valid = 0;
    chk("t3_r0_started", bus.core_start, 1'b1);
    wait_pvalid(0, n);
    release_resp(0);

    // 4: ena low for 4 cycles in WAIT
    stub_l = 3;
    send(0, B1, K0);
    tick();
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_start_low", bus.core_start, 1'b0);
      chk("t4_busy_hold", busy, 1'b1);
      chk("t4_no_resp", bus.p0_valid, 1'b0);
    end
    ena = 1'b1;
    wait_pvalid(0, m);
    chk("t4_latency", 128'(5 + m), 128'd8);
    release_resp(0);

    // 5: reset in WAIT, late core_done ignored, then an r1 job
    stub_l = 8;
    send(0, B0, K1);
    tick();
    tick();
    pulse_reset();
    chk("t5_busy", busy, 1'b0);
    chk("t5_p0_valid", bus.p0_valid, 1'b0);
    chk("t5_p0_block", bus.p0_block, '0);
    chk("t5_p1_block", bus.p1_block, '0);
    chk("t5_core_block", bus.core_block, '0);
    chk("t5_core_key", bus.core_key, '0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_stay_idle", busy, 1'b0);
      chk("t5_no_p0", bus.p0_valid, 1'b0);
    end
    stub_l = 2;
    send(1, B0, K1);
    wait_pvalid(1, n);
    chk("t5_r1_block", bus.p1_block, 128'h0000_0000_0000_0000_FEDC_BA98_7654_3210);
    release_resp(1);

`ifdef DEC_TIMEOUT_EN
    // 6: timeout, then done on the timeout cycle
    stub_never = 1'b1;
    send(0, B0, K0);
    wait_pvalid(0, n);
    chk("t6_to_latency", 128'(n), 128'd17);
    chk("t6_to_err", bus.p0_err, 1'b1);
    chk("t6_to_block", bus.p0_block, '0);
    release_resp(0);
    stub_never = 1'b0;
    stub_l = 16;
    send(0, B0, K0);
    wait_pvalid(0, n);
    chk("t6_edge_latency", 128'(n), 128'd17);
    chk("t6_edge_err", bus.p0_err, 1'b0);
    chk("t6_edge_block", bus.p0_block, 128'h0000_0000_0000_0000_FEDC_BA98_7654_3210);
    release_resp(0);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
